// File: rtl/caliptra_prim_edge_evt_arb.sv
// rtl/caliptra_prim_edge_evt_arb.sv - per-channel edge capture with round-robin event offer.
// Optional lost-edge counter enabled by CALIPTRA_PRIM_EDGE_EVT_ARB_DROP_CNT_EN.

module caliptra_prim_edge_detector #(
  parameter int unsigned       Width      = 1,
  parameter bit                EnSync     = 1'b1,
  parameter logic [Width-1:0]  ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] d_pos_o,
  output logic [Width-1:0] d_neg_o
);

  logic [Width-1:0] lvl;
  logic [Width-1:0] hist_q;

  if (EnSync) begin : g_sync
    logic [Width-1:0] sync1_q, sync2_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        sync1_q <= ResetValue;
        sync2_q <= ResetValue;
      end else begin
        sync1_q <= d_i;
        sync2_q <= sync1_q;
      end
    end
    assign lvl = sync2_q;
  end else begin : g_nosync
    assign lvl = d_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) hist_q <= ResetValue;
    else         hist_q <= lvl;
  end

  assign d_pos_o = lvl & ~hist_q;
  assign d_neg_o = ~lvl & hist_q;

endmodule

module caliptra_prim_edge_evt_arb #(
  parameter int unsigned         NumChan    = 4,
  parameter bit                  EnSync     = 1'b1,
  parameter logic [NumChan-1:0]  ResetValue = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NumChan-1:0]         d_i,
  input  logic [NumChan-1:0]         chan_en_i,
  input  logic                       pos_en_i,
  input  logic                       neg_en_i,
  output logic                       evt_valid_o,
  input  logic                       evt_ready_i,
  output logic [$clog2(NumChan)-1:0] evt_chan_o,
  output logic                       evt_neg_o,
  output logic [2*NumChan-1:0]       pending_o,
  output logic                       ovf_o,
  output logic [7:0]                 drop_cnt_o,
  input  logic                       drop_cnt_clr_i
);

  localparam int unsigned NReq = 2 * NumChan;
  localparam int unsigned IdxW = $clog2(NReq);

  typedef enum logic {IDLE, OFFER} state_e;

  logic [NumChan-1:0] pos, neg;
  logic [NReq-1:0]    set_vec, clr_vec, pend_q, pend_d;
  logic               loss, accept, ovf_q;
  state_e             state_q, state_d;
  logic [IdxW-1:0]    ptr_q, ptr_d, win_q, win_d, rr_idx;
  logic               rr_found;
  logic [IdxW:0]      cand;

  caliptra_prim_edge_detector #(
    .Width      (NumChan),
    .EnSync     (EnSync),
    .ResetValue (ResetValue)
  ) u_edge (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .d_i     (d_i),
    .d_pos_o (pos),
    .d_neg_o (neg)
  );

  // Requester 2c is the rising edge of channel c, 2c+1 its falling edge.
  always_comb begin
    set_vec = '0;
    for (int c = 0; c < NumChan; c++) begin
      set_vec[2*c]   = pos[c] & chan_en_i[c] & pos_en_i;
      set_vec[2*c+1] = neg[c] & chan_en_i[c] & neg_en_i;
    end
  end

  always_comb begin
    rr_idx   = '0;
    rr_found = 1'b0;
    cand     = '0;
    for (int k = 0; k < NReq; k++) begin
      cand = {1'b0, ptr_q} + (IdxW+1)'(k);
      if (cand >= (IdxW+1)'(NReq)) cand = cand - (IdxW+1)'(NReq);
      if (!rr_found && pend_q[cand[IdxW-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = cand[IdxW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (rr_found) begin
          state_d = OFFER;
          win_d   = rr_idx;
          ptr_d   = (rr_idx == IdxW'(NReq - 1)) ? '0 : rr_idx + IdxW'(1);
        end
      end
      OFFER: begin
        if (evt_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept  = (state_q == OFFER) & evt_ready_i;
  assign clr_vec = accept ? (NReq'(1) << win_q) : '0;
  // A fresh capture on the bit being retired keeps it set and is not a loss.
  assign pend_d  = (pend_q & ~clr_vec) | set_vec;
  assign loss    = |(set_vec & pend_q & ~clr_vec);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      pend_q  <= pend_d;
      ovf_q   <= loss;
    end
  end

  assign evt_valid_o = (state_q == OFFER);
  assign evt_chan_o  = evt_valid_o ? win_q[IdxW-1:1] : '0;
  assign evt_neg_o   = evt_valid_o & win_q[0];
  assign pending_o   = pend_q;
  assign ovf_o       = ovf_q;

`ifdef CALIPTRA_PRIM_EDGE_EVT_ARB_DROP_CNT_EN
  logic [7:0] drop_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                      drop_q <= '0;
    else if (drop_cnt_clr_i)          drop_q <= '0;
    else if (loss && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
  end
  assign drop_cnt_o = drop_q;
`else
  logic unused_drop_cnt_clr;
  assign unused_drop_cnt_clr = drop_cnt_clr_i;
  assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_caliptra_prim_edge_evt_arb.sv
// tb/tb_caliptra_prim_edge_evt_arb.sv - randomized and directed bench with reference model.

module tb_caliptra_prim_edge_evt_arb;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b1;
  logic [3:0] d_i = '0;
  logic [3:0] chan_en_i = '0;
  logic       pos_en_i = 1'b0;
  logic       neg_en_i = 1'b0;
  logic       evt_valid_o;
  logic       evt_ready_i = 1'b0;
  logic [1:0] evt_chan_o;
  logic       evt_neg_o;
  logic [7:0] pending_o;
  logic       ovf_o;
  logic [7:0] drop_cnt_o;
  logic       drop_cnt_clr_i = 1'b0;

  always #5 clk = ~clk;

  caliptra_prim_edge_evt_arb #(
    .NumChan    (4),
    .EnSync     (1'b1),
    .ResetValue (4'b0000)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .d_i            (d_i),
    .chan_en_i      (chan_en_i),
    .pos_en_i       (pos_en_i),
    .neg_en_i       (neg_en_i),
    .evt_valid_o    (evt_valid_o),
    .evt_ready_i    (evt_ready_i),
    .evt_chan_o     (evt_chan_o),
    .evt_neg_o      (evt_neg_o),
    .pending_o      (pending_o),
    .ovf_o          (ovf_o),
    .drop_cnt_o     (drop_cnt_o),
    .drop_cnt_clr_i (drop_cnt_clr_i)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: the level seen by edge logic lags the pin by two samples.
  bit         m_off;
  int         m_idx, m_ptr, m_drop;
  logic [7:0] m_pend;
  logic       m_ovf;
  logic [3:0] hist[$];

  function automatic void model_reset();
    m_off = 0; m_idx = 0; m_ptr = 0; m_drop = 0; m_pend = '0; m_ovf = 1'b0;
    hist = '{4'h0, 4'h0, 4'h0};
  endfunction

  task automatic model_edge(input logic [3:0] d, input logic [3:0] ce, input logic pe,
                            input logic ne, input logic rdy, input logic clr);
    logic [3:0] cur, prv;
    logic [7:0] setv;
    int         clr_idx;
    bit         lost;
    cur = hist[1];
    prv = hist[0];
    setv = '0;
    for (int c = 0; c < 4; c++) begin
      if (ce[c] && pe && cur[c] && !prv[c]) setv[2*c] = 1'b1;
      if (ce[c] && ne && !cur[c] && prv[c]) setv[2*c+1] = 1'b1;
    end
    clr_idx = (m_off && rdy) ? m_idx : -1;
    lost = 0;
    for (int i = 0; i < 8; i++)
      if (setv[i] && m_pend[i] && i != clr_idx) lost = 1;
    m_ovf = lost;
`ifdef CALIPTRA_PRIM_EDGE_EVT_ARB_DROP_CNT_EN
    if (clr) m_drop = 0;
    else if (lost && m_drop < 255) m_drop++;
`else
    if (clr) m_drop = 0;
`endif
    if (m_off) begin
      if (rdy) m_off = 0;
    end else if (m_pend != 0) begin
      for (int k = 0; k < 8; k++) begin
        if (m_pend[(m_ptr + k) % 8]) begin
          m_idx = (m_ptr + k) % 8;
          break;
        end
      end
      m_ptr = (m_idx + 1) % 8;
      m_off = 1;
    end
    if (clr_idx >= 0) m_pend[clr_idx] = 1'b0;
    m_pend = m_pend | setv;
    hist.push_back(d);
    void'(hist.pop_front());
  endtask

  task automatic step(input logic [3:0] d, input logic [3:0] ce, input logic pe,
                      input logic ne, input logic rdy, input logic clr);
    d_i = d; chan_en_i = ce; pos_en_i = pe; neg_en_i = ne;
    evt_ready_i = rdy; drop_cnt_clr_i = clr;
    model_edge(d, ce, pe, ne, rdy, clr);
    @(posedge clk);
    @(negedge clk);
    check("valid",   evt_valid_o, m_off);
    check("chan",    evt_chan_o,  m_off ? m_idx / 2 : 0);
    check("neg",     evt_neg_o,   m_off ? m_idx % 2 : 0);
    check("pending", pending_o,   m_pend);
    check("ovf",     ovf_o,       m_ovf);
    check("drop",    drop_cnt_o,  m_drop);
  endtask

  task automatic step_s(input logic [3:0] d, input logic rdy);
    step(d, 4'hF, 1'b1, 1'b1, rdy, 1'b0);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    #1;
    check("rst_valid",   evt_valid_o, 0);
    check("rst_chan",    evt_chan_o,  0);
    check("rst_neg",     evt_neg_o,   0);
    check("rst_pending", pending_o,   0);
    check("rst_ovf",     ovf_o,       0);
    check("rst_drop",    drop_cnt_o,  0);
    model_reset();
    d_i = '0; evt_ready_i = 1'b0; drop_cnt_clr_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  logic [1:0] got_chan[$];
  logic       got_neg[$];
  int         got_cyc[$];
  int         ovf_cnt, exp_drop;
  logic [7:0] pend_seen;
  logic       valid_seen;
  logic [3:0] cur_d, ce_r;

  initial begin
    @(negedge clk);
    do_reset();

    // single rising edge on channel 2: latency and accept
    step_s(4'b0000, 1'b0);
    step_s(4'b0100, 1'b0);
    step_s(4'b0100, 1'b0);
    step_s(4'b0100, 1'b0);
    check("lat_e2_valid", evt_valid_o, 0);
    step_s(4'b0100, 1'b0);
    check("lat_e3_valid", evt_valid_o, 1);
    check("lat_e3_chan",  evt_chan_o,  2);
    check("lat_e3_neg",   evt_neg_o,   0);
    step_s(4'b0100, 1'b1);
    check("accept_pending", pending_o, 0);

    // simultaneous rises on 0,1,3 then falls on 1,3 probe the pointer
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step_s(4'b1011, 1'b1);
      if (evt_valid_o) begin
        got_chan.push_back(evt_chan_o);
        got_cyc.push_back(i);
      end
    end
    check("rr_count", got_chan.size(), 3);
    if (got_chan.size() == 3) begin
      check("rr_first",  got_chan[0], 0);
      check("rr_second", got_chan[1], 1);
      check("rr_third",  got_chan[2], 3);
      check("rr_gap1",   got_cyc[1] - got_cyc[0], 2);
      check("rr_gap2",   got_cyc[2] - got_cyc[1], 2);
    end
    got_chan.delete();
    for (int i = 0; i < 10; i++) begin
      step_s(4'b0001, 1'b1);
      if (evt_valid_o) begin
        got_chan.push_back(evt_chan_o);
        got_neg.push_back(evt_neg_o);
      end
    end
    check("ptr_count", got_chan.size(), 2);
    if (got_chan.size() == 2) begin
      check("ptr_first_chan",  got_chan[0], 3);
      check("ptr_first_neg",   got_neg[0],  1);
      check("ptr_second_chan", got_chan[1], 1);
    end

    // repeated rise on a pending requester while stalled
    do_reset();
    repeat (5) step_s(4'b0010, 1'b0);
    check("ovf_pre_valid", evt_valid_o, 1);
    ovf_cnt = 0;
    step_s(4'b0000, 1'b0);
    if (ovf_o) ovf_cnt++;
    repeat (5) begin
      step_s(4'b0010, 1'b0);
      if (ovf_o) ovf_cnt++;
    end
    check("ovf_pulses",   ovf_cnt,     1);
    check("ovf_offer_ch", evt_chan_o,  1);
    check("ovf_offer_ng", evt_neg_o,   0);
`ifdef CALIPTRA_PRIM_EDGE_EVT_ARB_DROP_CNT_EN
    exp_drop = 1;
`else
    exp_drop = 0;
`endif
    check("ovf_drop", drop_cnt_o, exp_drop);

    // channel and type enables gate capture
    do_reset();
    pend_seen = '0; valid_seen = 1'b0;
    step(4'b0100, 4'b1011, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (5) begin
      step(4'b0000, 4'b1011, 1'b1, 1'b1, 1'b1, 1'b0);
      pend_seen |= pending_o; valid_seen |= evt_valid_o;
    end
    check("chen_pending", pend_seen,  0);
    check("chen_valid",   valid_seen, 0);
    repeat (6) step(4'b0001, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0);
    pend_seen = '0;
    repeat (6) begin
      step(4'b0000, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0);
      pend_seen |= pending_o;
    end
    check("negen_pending", pend_seen, 0);

    // reset in the middle of an offer
    do_reset();
    repeat (4) step_s(4'b0001, 1'b0);
    check("midrst_pre_valid", evt_valid_o, 1);
    do_reset();
    valid_seen = 1'b0;
    repeat (20) begin
      step_s(4'b0000, 1'b0);
      valid_seen |= evt_valid_o;
    end
    check("midrst_no_evt", valid_seen, 0);

    // saturating drop counter, clear beats increment
    do_reset();
    for (int i = 0; i < 300; i++) step_s((i % 2 == 0) ? 4'b0010 : 4'b0000, 1'b0);
`ifdef CALIPTRA_PRIM_EDGE_EVT_ARB_DROP_CNT_EN
    exp_drop = 255;
`else
    exp_drop = 0;
`endif
    check("sat_drop", drop_cnt_o, exp_drop);
    step(4'b0010, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1);
    check("clr_ovf",  ovf_o,      1);
    check("clr_drop", drop_cnt_o, 0);

    // randomized traffic
    do_reset();
    cur_d = '0;
    for (int i = 0; i < 800; i++) begin
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(0, 3) == 0) cur_d[c] = ~cur_d[c];
        ce_r[c] = ($urandom_range(0, 7) != 0);
      end
      step(cur_d, ce_r, ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0),
           1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/caliptra_prim_edge_evt_arb.md
CALIPTRA_PRIM_EDGE_EVT_ARB -- requirements
Module: caliptra_prim_edge_evt_arb

Interface
REQ-001 SHALL have parameter NumChan, default 4, giving the number of input channels (range 2..16).
REQ-002 SHALL have parameter EnSync, default 1'b1; when 1, each channel passes through a 2-flop synchronizer before edge detection.
REQ-003 SHALL have parameter ResetValue, logic [NumChan-1:0], default '0, giving the reset level of the synchronizer and the edge-history flops.
REQ-004 SHALL have ports (name, direction, width, meaning):
- clk_i, input, 1: the single clock.
- rst_ni, input, 1: reset, asynchronous, active-low.
- d_i, input, NumChan: glitch-free level inputs.
- chan_en_i, input, NumChan: per-channel capture enable.
- pos_en_i, input, 1: capture rising edges.
- neg_en_i, input, 1: capture falling edges.
- evt_valid_o, output, 1: event offered.
- evt_ready_i, input, 1: consumer accepts.
- evt_chan_o, output, $clog2(NumChan): channel of the offered event.
- evt_neg_o, output, 1: offered event type (0 = rising, 1 = falling).
- pending_o, output, 2*NumChan: pending bits, index 2*c+type.
- ovf_o, output, 1: single-cycle pulse, edge lost.
- drop_cnt_o, output, 8: count of lost edges.
- drop_cnt_clr_i, input, 1: synchronous clear of drop_cnt_o.

Function
REQ-005 SHALL detect edges per channel using caliptra_prim_edge_detector, with EnSync and ResetValue passed through.
REQ-006 SHALL set pending[2c] on a rising pulse and pending[2c+1] on a falling pulse, only when chan_en_i[c] and pos_en_i/neg_en_i respectively are 1; the bit is set one clock after the pulse.
REQ-007 SHALL keep already-pending bits when chan_en_i, pos_en_i or neg_en_i deassert; enables gate only new captures.
REQ-008 SHALL implement FSM IDLE/OFFER:
- IDLE -> OFFER when any pending bit is set; register the round-robin winner; evt_valid_o rises on that same clock.
- OFFER -> IDLE on evt_valid_o & evt_ready_i.
REQ-009 SHALL search round-robin over the 2*NumChan requesters, starting at (last granted index + 1) mod 2*NumChan; the pointer is 0 after reset.
REQ-010 SHALL hold evt_valid_o, evt_chan_o and evt_neg_o stable in OFFER until accepted; new edges SHALL NOT change the offered event.
REQ-011 SHALL clear the granted pending bit on the accept clock; if the same requester captures a new edge on that clock, the bit SHALL remain set and no overflow occurs.
REQ-012 SHALL leave one IDLE cycle between accept and the next evt_valid_o (maximum one event per 2 cycles).
REQ-013 SHALL pulse ovf_o for one cycle when a captured edge hits an already-set pending bit that is not being cleared that cycle; multiple simultaneous losses give one pulse.
REQ-014 SHALL drive evt_chan_o and evt_neg_o to 0 while evt_valid_o is 0.
REQ-015 Latency: d_i sampled at edge E -> evt_valid_o high after edge E+3 (EnSync=1) or E+1 (EnSync=0), assuming idle and no competitors.

Reset
REQ-016 SHALL, while rst_ni is low, asynchronously force:
- FSM to IDLE, pointer to 0, and pending_o to 0.
- evt_valid_o, evt_chan_o, evt_neg_o, ovf_o and drop_cnt_o to 0.
- synchronizer and edge-history flops to ResetValue.
REQ-017 SHALL, on reset asserted mid-offer, drop the offered event without completing the handshake; after release, no edge SHALL be reported for inputs equal to ResetValue.

Configuration
REQ-018 With CALIPTRA_PRIM_EDGE_EVT_ARB_DROP_CNT_EN defined, drop_cnt_o SHALL:
- increment by 1 on each ovf_o pulse, saturating at 8'hFF;
- clear to 0 on drop_cnt_clr_i, with clear taking priority over increment.
REQ-019 Without CALIPTRA_PRIM_EDGE_EVT_ARB_DROP_CNT_EN, drop_cnt_o SHALL be tied to 0, drop_cnt_clr_i SHALL be ignored, and no counter flops SHALL exist.

Verification
REQ-020 EnSync=1, all enables 1, d_i[2] 0->1 sampled at edge 10 -> evt_valid_o=1 after edge 13 with evt_chan_o=2, evt_neg_o=0; ready=1 at edge 14 -> pending_o=0 after edge 14.
REQ-021 Channels 0, 1 and 3 rise on the same clock, ready held 1 -> grants in order chan 0, 1, 3, one event every 2 cycles; pointer then at index 7.
REQ-022 ready held 0 while chan 1 is pending rising, then chan 1 rises again -> one ovf_o pulse, drop_cnt_o=1 (macro defined) or 0 (undefined); the offered event is unchanged.
REQ-023 chan_en_i=4'b1011, pulse on d_i[2] -> no pending bit set, evt_valid_o stays 0; neg_en_i=0 and chan 0 falls -> no capture.
REQ-024 rst_ni low while evt_valid_o=1 -> all outputs 0 immediately; after release with d_i=ResetValue, no event for 20 cycles.
REQ-025 Macro defined, 300 forced overflows -> drop_cnt_o=8'hFF; drop_cnt_clr_i together with an overflow -> drop_cnt_o=0.
